backprop_error_propagate: RTL

- Consumes the per-output cost/delta vector produced at the loss stage and propagates it one layer backward through that layer's weight matrix.
- Computes the upstream error vector e[j] = sum over i of w[i][j] * delta[i].
- Uses one multiply-accumulate per clock, driven by a start/busy/done handshake.
- Sits between the cost-gradient stage and the previous layer's backprop logic.
- Operands use the same packed-stream format as the rest of the network datapath.

---
 rtl/backprop_error_propagate.sv | 124 ++++++++++++
 1 files changed

// File: rtl/backprop_error_propagate.sv
// Backward error propagation through one layer: e[j] = sum_i w[i][j] * delta[i],
// computed with one signed multiply-accumulate per clock and a saturated result.
module backprop_error_propagate #(
  parameter int data_size = 4,
  parameter int in_size   = 3,
  parameter int out_size  = 3,
  parameter int frac_bits = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [data_size*out_size-1:0]         delta_stream,
  input  logic [data_size*out_size*in_size-1:0] weight_stream,
  output logic                                  busy,
  output logic                                  done,
  output logic [data_size*in_size-1:0]          error_stream,
  output logic [1:0]                            state_dbg
);

  // Handshake: start is a level sampled only in IDLE; busy is high from the
  // edge that accepts start until DONE is left; done is a one-cycle pulse and
  // error_stream holds that result until the next DONE (or reset).

  localparam int IW = (out_size > 1) ? $clog2(out_size) : 1;
  localparam int JW = (in_size > 1) ? $clog2(in_size) : 1;
  localparam int PW = 2 * data_size;
  localparam int AW = PW + $clog2(out_size);
  localparam int SAT_HI = 2 ** (data_size - 1) - 1;
  localparam int SAT_LO = -(2 ** (data_size - 1));
  localparam logic signed [AW-1:0] ACC_HI = AW'(SAT_HI);
  localparam logic signed [AW-1:0] ACC_LO = AW'(SAT_LO);
  localparam logic [IW-1:0] I_LAST = IW'(out_size - 1);
  localparam logic [JW-1:0] J_LAST = JW'(in_size - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [IW-1:0]             i;
  logic [JW-1:0]             j;
  logic signed [AW-1:0]      acc;
  logic signed [data_size-1:0] delta_a  [out_size];
  logic signed [data_size-1:0] weight_a [out_size][in_size];
  logic signed [data_size-1:0] shadow   [in_size];

  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        sum;
  logic signed [AW-1:0]        shifted;
  logic signed [data_size-1:0] sat_val;
  logic [data_size*in_size-1:0] err_pack;

  always_comb begin
    prod    = weight_a[i][j] * delta_a[i];
    sum     = acc + AW'(prod);
    shifted = sum >>> frac_bits;
    if (shifted > ACC_HI) sat_val = data_size'(SAT_HI);
    else if (shifted < ACC_LO) sat_val = data_size'(SAT_LO);
    else sat_val = shifted[data_size-1:0];
    // The final column is still in flight on the completing edge, so splice it in.
    err_pack = '0;
    for (int k = 0; k < in_size; k++) begin
      if (JW'(k) == j) err_pack[(in_size-k)*data_size-1 -: data_size] = sat_val;
      else err_pack[(in_size-k)*data_size-1 -: data_size] = shadow[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      i            <= '0;
      j            <= '0;
      acc          <= '0;
      error_stream <= '0;
      for (int a = 0; a < out_size; a++) begin
        delta_a[a] <= '0;
        for (int b = 0; b < in_size; b++) weight_a[a][b] <= '0;
      end
      for (int b = 0; b < in_size; b++) shadow[b] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int a = 0; a < out_size; a++) begin
              delta_a[a] <= delta_stream[(out_size-a)*data_size-1 -: data_size];
              for (int b = 0; b < in_size; b++)
                weight_a[a][b] <= weight_stream[(out_size*in_size-(a*in_size+b))*data_size-1 -: data_size];
            end
            i     <= '0;
            j     <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= sum;
          if (i == I_LAST) begin
            shadow[j] <= sat_val;
            acc       <= '0;
            i         <= '0;
            if (j == J_LAST) begin
              j            <= '0;
              error_stream <= err_pack;
              state        <= S_DONE;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule
